// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// Combined memory-access / write-back stage of a small accumulator machine.
// It accepts one instruction at a time from EX using a valid/ready handshake.
// The instruction is classified as one of the following:
//   - a taken branch: redirect pulse to IF, then retire.
//   - an illegal control code: illegal pulse only, no retire.
//   - a memory op (load or store): one request is held until acknowledged
//     or until it times out.
//   - a register op: optional accumulator write, then retire.
//
// Ports
//   clk, reset           sole rising-edge clock, synchronous active-high reset
//   iValid_EX            EX presents an instruction this cycle
//   oReady_MEM           stage is idle and can accept an instruction
//   iBranchTaken_EX      branch resolved taken
//   iBranchDir_EX[9:0]   branch target, or memory address for loads/stores
//   iAluData_EX[7:0]     ALU result / store data / constant
//   iControlAcum_EX[2:0] accumulator control code
//   iMemEnable_EX        instruction accesses data memory
//   oMemReq/oMemWrite/oMemAddr/oMemWrData
//                        memory request, held stable until iMemAck
//   iMemAck, iMemRdData  memory completion and read data
//   oAcumA, oAcumB       registered accumulators
//   oBranchTaken_MEM, oBranchDir_MEM
//                        one-cycle redirect pulse and its target
//   oRetire              one-cycle pulse per completed instruction
//   oIllegal             one-cycle pulse on an undefined control code
//   oMemErr              sticky flag, set when a request times out
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iValid_EX,
  output logic       oReady_MEM,
  input  logic       iBranchTaken_EX,
  input  logic [9:0] iBranchDir_EX,
  input  logic [7:0] iAluData_EX,
  input  logic [2:0] iControlAcum_EX,
  input  logic       iMemEnable_EX,
  output logic       oMemReq,
  output logic       oMemWrite,
  output logic [9:0] oMemAddr,
  output logic [7:0] oMemWrData,
  input  logic       iMemAck,
  input  logic [7:0] iMemRdData,
  output logic [7:0] oAcumA,
  output logic [7:0] oAcumB,
  output logic       oBranchTaken_MEM,
  output logic [9:0] oBranchDir_MEM,
  output logic       oRetire,
  output logic       oIllegal,
  output logic       oMemErr
);

  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  // The counter holds the number of un-acked ACCESS cycles that have already
  // elapsed. Therefore, the cycle in which it equals ACK_TIMEOUT-1 is the
  // last chance for an ack.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  localparam logic [2:0] CTRL_NO_LOAD   = 3'b000;
  localparam logic [2:0] CTRL_CONST_A   = 3'b001;
  localparam logic [2:0] CTRL_MEMORY_A  = 3'b010;
  localparam logic [2:0] CTRL_CONST_B   = 3'b011;
  localparam logic [2:0] CTRL_MEMORY_B  = 3'b100;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       acum_a_q, acum_a_d;
  logic [7:0]       acum_b_q, acum_b_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_write_q, mem_write_d;
  logic [9:0]       mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wr_data_q, mem_wr_data_d;
  logic             is_load_q, is_load_d;
  logic             dest_b_q, dest_b_d;
  logic             branch_taken_q, branch_taken_d;
  logic [9:0]       branch_dir_q, branch_dir_d;
  logic             retire_q, retire_d;
  logic             illegal_q, illegal_d;
  logic             mem_err_q, mem_err_d;

  logic accept;
  logic ctrl_illegal;
  logic mem_op;

  // Instruction decode. Codes 001/011 with the memory enable set are plain
  // register ops, so only 000/010/100 can reach memory. With the enable set,
  // the only invalid combinations are the undefined codes 101..111.
  always_comb begin
    accept       = iValid_EX && (state_q == IDLE);
    ctrl_illegal = (iControlAcum_EX > CTRL_MEMORY_B);
    mem_op       = iMemEnable_EX &&
                   ((iControlAcum_EX == CTRL_NO_LOAD)  ||
                    (iControlAcum_EX == CTRL_MEMORY_A) ||
                    (iControlAcum_EX == CTRL_MEMORY_B));
  end

  // Next-state and output logic. A taken branch takes priority over every
  // other classification, because a redirected instruction must not touch
  // the accumulators or memory.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    acum_a_d       = acum_a_q;
    acum_b_d       = acum_b_q;
    mem_req_d      = mem_req_q;
    mem_write_d    = mem_write_q;
    mem_addr_d     = mem_addr_q;
    mem_wr_data_d  = mem_wr_data_q;
    is_load_d      = is_load_q;
    dest_b_d       = dest_b_q;
    branch_taken_d = 1'b0;
    branch_dir_d   = branch_dir_q;
    retire_d       = 1'b0;
    illegal_d      = 1'b0;
    mem_err_d      = mem_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (iBranchTaken_EX) begin
            branch_taken_d = 1'b1;
            branch_dir_d   = iBranchDir_EX;
            retire_d       = 1'b1;
          end else if (ctrl_illegal) begin
            illegal_d = 1'b1;
          end else if (mem_op) begin
            state_d       = ACCESS;
            cnt_d         = '0;
            mem_req_d     = 1'b1;
            mem_write_d   = (iControlAcum_EX == CTRL_NO_LOAD);
            mem_addr_d    = iBranchDir_EX;
            mem_wr_data_d = iAluData_EX;
            is_load_d     = (iControlAcum_EX != CTRL_NO_LOAD);
            dest_b_d      = (iControlAcum_EX == CTRL_MEMORY_B);
          end else begin
            case (iControlAcum_EX)
              CTRL_CONST_A, CTRL_MEMORY_A: acum_a_d = iAluData_EX;
              CTRL_CONST_B, CTRL_MEMORY_B: acum_b_d = iAluData_EX;
              default: ;
            endcase
            retire_d = 1'b1;
          end
        end
      end

      ACCESS: begin
        // An ack wins over a timeout that would expire in the same cycle.
        if (iMemAck) begin
          if (is_load_q) begin
            if (dest_b_q) begin
              acum_b_d = iMemRdData;
            end else begin
              acum_a_d = iMemRdData;
            end
          end
          mem_req_d   = 1'b0;
          mem_write_d = 1'b0;
          cnt_d       = '0;
          retire_d    = 1'b1;
          state_d     = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d   = 1'b0;
          mem_write_d = 1'b0;
          cnt_d       = '0;
          mem_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset overrides any accept or ack sampled on the same
  // edge, and it abandons an outstanding request without writing back.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      acum_a_q       <= '0;
      acum_b_q       <= '0;
      mem_req_q      <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_addr_q     <= '0;
      mem_wr_data_q  <= '0;
      is_load_q      <= 1'b0;
      dest_b_q       <= 1'b0;
      branch_taken_q <= 1'b0;
      branch_dir_q   <= '0;
      retire_q       <= 1'b0;
      illegal_q      <= 1'b0;
      mem_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      acum_a_q       <= acum_a_d;
      acum_b_q       <= acum_b_d;
      mem_req_q      <= mem_req_d;
      mem_write_q    <= mem_write_d;
      mem_addr_q     <= mem_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      is_load_q      <= is_load_d;
      dest_b_q       <= dest_b_d;
      branch_taken_q <= branch_taken_d;
      branch_dir_q   <= branch_dir_d;
      retire_q       <= retire_d;
      illegal_q      <= illegal_d;
      mem_err_q      <= mem_err_d;
    end
  end

  always_comb begin
    oReady_MEM       = (state_q == IDLE);
    oMemReq          = mem_req_q;
    oMemWrite        = mem_write_q;
    oMemAddr         = mem_addr_q;
    oMemWrData       = mem_wr_data_q;
    oAcumA           = acum_a_q;
    oAcumB           = acum_b_q;
    oBranchTaken_MEM = branch_taken_q;
    oBranchDir_MEM   = branch_dir_q;
    oRetire          = retire_q;
    oIllegal         = illegal_q;
    oMemErr          = mem_err_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Scoreboard bench for mem_wb_stage. For each instruction, the stimulus
// process works out the architectural outcome (accumulators, error flag,
// memory request contents and duration). It then queues the observable
// events that should follow. A separate monitor runs on the falling edge and
// pops one event from the queue each time the DUT shows a request start, a
// request end, a retire, a branch redirect or an illegal pulse.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

  localparam int ACK_TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       iValid_EX;
  logic       oReady_MEM;
  logic       iBranchTaken_EX;
  logic [9:0] iBranchDir_EX;
  logic [7:0] iAluData_EX;
  logic [2:0] iControlAcum_EX;
  logic       iMemEnable_EX;
  logic       oMemReq;
  logic       oMemWrite;
  logic [9:0] oMemAddr;
  logic [7:0] oMemWrData;
  logic       iMemAck;
  logic [7:0] iMemRdData;
  logic [7:0] oAcumA;
  logic [7:0] oAcumB;
  logic       oBranchTaken_MEM;
  logic [9:0] oBranchDir_MEM;
  logic       oRetire;
  logic       oIllegal;
  logic       oMemErr;

  always #5 clk = ~clk;

  mem_wb_stage #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk              (clk),
    .reset            (reset),
    .iValid_EX        (iValid_EX),
    .oReady_MEM       (oReady_MEM),
    .iBranchTaken_EX  (iBranchTaken_EX),
    .iBranchDir_EX    (iBranchDir_EX),
    .iAluData_EX      (iAluData_EX),
    .iControlAcum_EX  (iControlAcum_EX),
    .iMemEnable_EX    (iMemEnable_EX),
    .oMemReq          (oMemReq),
    .oMemWrite        (oMemWrite),
    .oMemAddr         (oMemAddr),
    .oMemWrData       (oMemWrData),
    .iMemAck          (iMemAck),
    .iMemRdData       (iMemRdData),
    .oAcumA           (oAcumA),
    .oAcumB           (oAcumB),
    .oBranchTaken_MEM (oBranchTaken_MEM),
    .oBranchDir_MEM   (oBranchDir_MEM),
    .oRetire          (oRetire),
    .oIllegal         (oIllegal),
    .oMemErr          (oMemErr)
  );

  typedef enum int {EV_REQ, EV_REQEND, EV_RETIRE, EV_BRANCH, EV_ILLEGAL} evKind_t;

  typedef struct {
    evKind_t    kind;
    logic [9:0] addr;
    logic       wr;
    logic [7:0] wdata;
    int         held;
    logic       err;
    logic [7:0] a;
    logic [7:0] b;
    logic [9:0] dir;
  } expEvent_t;

  expEvent_t expQ[$];
  int        testsRun = 0;
  int        testsFailed = 0;

  // Reference model state.
  logic [7:0] mA = 8'h00;
  logic [7:0] mB = 8'h00;
  logic       mErr = 1'b0;
  logic       expReady = 1'b1;
  logic       monitorOn = 1'b0;

  // Monitor bookkeeping.
  expEvent_t curReq;
  logic      prevReq = 1'b0;
  int        heldCnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic expEvent_t blankEvent(input evKind_t kind);
    expEvent_t ev;
    ev.kind  = kind;
    ev.addr  = '0;
    ev.wr    = 1'b0;
    ev.wdata = '0;
    ev.held  = 0;
    ev.err   = 1'b0;
    ev.a     = mA;
    ev.b     = mB;
    ev.dir   = '0;
    return ev;
  endfunction

  task automatic popExpected(input evKind_t kind, output expEvent_t ev, output bit ok);
    ev = blankEvent(kind);
    ok = 1'b0;
    if (expQ.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL unexpected %s: DUT produced it, scoreboard held nothing", kind.name());
    end else begin
      ev = expQ.pop_front();
      checkOutput({"event order at ", kind.name()}, int'(kind), int'(ev.kind));
      ok = (ev.kind == kind);
    end
  endtask

  // Issue a single instruction and play the memory side for it. The expected
  // outcome comes directly from the instruction rules: a branch beats
  // everything else, codes above 100 are illegal, and enabled 000/010/100
  // codes go to memory. Everything else is a register write into A (001/010)
  // or B (011/100). A memory op that is acked in access cycle k (1..15)
  // completes. Any later ack causes a timeout after 15 cycles.
  task automatic applyStimulus(input bit br, input logic [9:0] dir, input logic [7:0] data,
                               input logic [2:0] ctrl, input bit memEn,
                               input int ackDelay, input logic [7:0] rd);
    expEvent_t ev;
    bit        isMem;
    int        w;
    w = 0;
    while (!oReady_MEM && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    if (!oReady_MEM) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL ready wait: got 0, expected 1 within 40 cycles");
      return;
    end
    isMem           = 1'b0;
    iValid_EX       = 1'b1;
    iBranchTaken_EX = br;
    iBranchDir_EX   = dir;
    iAluData_EX     = data;
    iControlAcum_EX = ctrl;
    iMemEnable_EX   = memEn;
    iMemAck         = 1'($urandom_range(0, 1));
    iMemRdData      = 8'($urandom);

    if (br) begin
      ev = blankEvent(EV_BRANCH);
      ev.dir = dir;
      expQ.push_back(ev);
    end else if (ctrl > 3'd4) begin
      expQ.push_back(blankEvent(EV_ILLEGAL));
    end else if (memEn && (ctrl == 3'd0 || ctrl == 3'd2 || ctrl == 3'd4)) begin
      isMem = 1'b1;
      ev = blankEvent(EV_REQ);
      ev.addr  = dir;
      ev.wr    = (ctrl == 3'd0);
      ev.wdata = data;
      expQ.push_back(ev);
      if (ackDelay <= ACK_TIMEOUT) begin
        if (ctrl == 3'd2) mA = rd;
        if (ctrl == 3'd4) mB = rd;
        ev = blankEvent(EV_REQEND);
        ev.held = ackDelay;
        ev.err  = mErr;
        expQ.push_back(ev);
        ev = blankEvent(EV_RETIRE);
        ev.err = mErr;
        expQ.push_back(ev);
      end else begin
        mErr = 1'b1;
        ev = blankEvent(EV_REQEND);
        ev.held = ACK_TIMEOUT;
        ev.err  = 1'b1;
        expQ.push_back(ev);
      end
    end else begin
      if (ctrl == 3'd1 || ctrl == 3'd2) mA = data;
      if (ctrl == 3'd3 || ctrl == 3'd4) mB = data;
      ev = blankEvent(EV_RETIRE);
      ev.err = mErr;
      expQ.push_back(ev);
    end

    @(posedge clk); #1;
    iValid_EX       = 1'b0;
    iMemAck         = 1'b0;
    iBranchTaken_EX = 1'($urandom_range(0, 1));
    iBranchDir_EX   = 10'($urandom);
    iAluData_EX     = 8'($urandom);
    iControlAcum_EX = 3'($urandom);
    iMemEnable_EX   = 1'($urandom_range(0, 1));
    if (isMem) begin
      expReady = 1'b0;
      for (int k = 1; k <= ACK_TIMEOUT; k++) begin
        iValid_EX  = 1'($urandom_range(0, 1));
        iMemAck    = (k == ackDelay);
        iMemRdData = (k == ackDelay) ? rd : 8'($urandom);
        @(posedge clk); #1;
        iMemAck = 1'b0;
        if (k == ackDelay) break;
      end
      iValid_EX = 1'b0;
      expReady  = 1'b1;
    end
  endtask

  // A load is started and then reset is asserted in its second access cycle,
  // together with an ack that must be ignored. After that, a reset arrives
  // together with an offered register op that must not be accepted.
  task automatic applyResetMidAccess();
    expEvent_t ev;
    ev = blankEvent(EV_REQ);
    ev.addr  = 10'h155;
    ev.wr    = 1'b0;
    ev.wdata = 8'h3C;
    expQ.push_back(ev);
    ev = blankEvent(EV_REQEND);
    ev.held = 2;
    ev.err  = 1'b0;
    ev.a    = 8'h00;
    ev.b    = 8'h00;
    expQ.push_back(ev);

    iValid_EX       = 1'b1;
    iBranchTaken_EX = 1'b0;
    iBranchDir_EX   = 10'h155;
    iAluData_EX     = 8'h3C;
    iControlAcum_EX = 3'd2;
    iMemEnable_EX   = 1'b1;
    @(posedge clk); #1;
    iValid_EX = 1'b0;
    expReady  = 1'b0;
    @(posedge clk); #1;
    reset      = 1'b1;
    iMemAck    = 1'b1;
    iMemRdData = 8'hEE;
    @(posedge clk); #1;
    reset    = 1'b0;
    iMemAck  = 1'b0;
    expReady = 1'b1;
    mA = 8'h00;
    mB = 8'h00;
    mErr = 1'b0;

    iValid_EX       = 1'b1;
    iControlAcum_EX = 3'd1;
    iMemEnable_EX   = 1'b0;
    iAluData_EX     = 8'h77;
    reset           = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    iValid_EX = 1'b0;
  endtask

  // The monitor turns DUT activity into scoreboard pops. Request starts and
  // ends are handled first, then the pulses, which matches the order in
  // which the stimulus queues events that land in the same cycle.
  always @(negedge clk) begin
    expEvent_t ev;
    bit        ok;
    if (monitorOn) begin
      if (oMemReq && !prevReq) begin
        popExpected(EV_REQ, ev, ok);
        if (ok) begin
          checkOutput("req addr", 32'(oMemAddr), 32'(ev.addr));
          checkOutput("req write", 32'(oMemWrite), 32'(ev.wr));
          checkOutput("req wdata", 32'(oMemWrData), 32'(ev.wdata));
        end
        curReq  = ev;
        heldCnt = 1;
      end else if (oMemReq) begin
        heldCnt++;
        checkOutput("req addr stable", 32'(oMemAddr), 32'(curReq.addr));
        checkOutput("req write stable", 32'(oMemWrite), 32'(curReq.wr));
        checkOutput("req wdata stable", 32'(oMemWrData), 32'(curReq.wdata));
      end
      if (!oMemReq && prevReq) begin
        popExpected(EV_REQEND, ev, ok);
        if (ok) begin
          checkOutput("req held cycles", 32'(heldCnt), 32'(ev.held));
          checkOutput("memErr at req end", 32'(oMemErr), 32'(ev.err));
          checkOutput("acumA at req end", 32'(oAcumA), 32'(ev.a));
          checkOutput("acumB at req end", 32'(oAcumB), 32'(ev.b));
        end
      end
      if (oBranchTaken_MEM) begin
        popExpected(EV_BRANCH, ev, ok);
        if (ok) begin
          checkOutput("branch dir", 32'(oBranchDir_MEM), 32'(ev.dir));
          checkOutput("branch retire", 32'(oRetire), 32'd1);
          checkOutput("acumA at branch", 32'(oAcumA), 32'(ev.a));
          checkOutput("acumB at branch", 32'(oAcumB), 32'(ev.b));
        end
      end else if (oRetire) begin
        popExpected(EV_RETIRE, ev, ok);
        if (ok) begin
          checkOutput("acumA at retire", 32'(oAcumA), 32'(ev.a));
          checkOutput("acumB at retire", 32'(oAcumB), 32'(ev.b));
          checkOutput("memErr at retire", 32'(oMemErr), 32'(ev.err));
        end
      end
      if (oIllegal) begin
        popExpected(EV_ILLEGAL, ev, ok);
        if (ok) begin
          checkOutput("illegal retire", 32'(oRetire), 32'd0);
          checkOutput("acumA at illegal", 32'(oAcumA), 32'(ev.a));
          checkOutput("acumB at illegal", 32'(oAcumB), 32'(ev.b));
        end
      end
      checkOutput("ready", 32'(oReady_MEM), 32'(expReady));
      prevReq = oMemReq;
    end
  end

  initial begin
    logic [2:0] ctrl;
    int         delay;
    reset           = 1'b1;
    iValid_EX       = 1'b0;
    iBranchTaken_EX = 1'b0;
    iBranchDir_EX   = '0;
    iAluData_EX     = '0;
    iControlAcum_EX = '0;
    iMemEnable_EX   = 1'b0;
    iMemAck         = 1'b0;
    iMemRdData      = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset ready", 32'(oReady_MEM), 32'd1);
    checkOutput("reset memReq", 32'(oMemReq), 32'd0);
    checkOutput("reset memWrite", 32'(oMemWrite), 32'd0);
    checkOutput("reset memAddr", 32'(oMemAddr), 32'd0);
    checkOutput("reset memWrData", 32'(oMemWrData), 32'd0);
    checkOutput("reset acumA", 32'(oAcumA), 32'd0);
    checkOutput("reset acumB", 32'(oAcumB), 32'd0);
    checkOutput("reset branchTaken", 32'(oBranchTaken_MEM), 32'd0);
    checkOutput("reset branchDir", 32'(oBranchDir_MEM), 32'd0);
    checkOutput("reset retire", 32'(oRetire), 32'd0);
    checkOutput("reset illegal", 32'(oIllegal), 32'd0);
    checkOutput("reset memErr", 32'(oMemErr), 32'd0);
    monitorOn = 1'b1;

    // Directed cases: register op, delayed load, immediate-ack store,
    // timeout and then a boundary ack, branch, illegal code, and reset.
    applyStimulus(1'b0, 10'h000, 8'h5A, 3'd1, 1'b0, 1, 8'h00);
    applyStimulus(1'b0, 10'h123, 8'h11, 3'd4, 1'b1, 3, 8'hC3);
    applyStimulus(1'b0, 10'h3FF, 8'h81, 3'd0, 1'b1, 1, 8'h00);
    applyStimulus(1'b0, 10'h0F0, 8'h22, 3'd2, 1'b1, ACK_TIMEOUT + 1, 8'h99);
    applyStimulus(1'b0, 10'h0F1, 8'h33, 3'd2, 1'b1, ACK_TIMEOUT, 8'h4D);
    applyStimulus(1'b1, 10'h2A0, 8'h44, 3'd1, 1'b0, 1, 8'h00);
    applyStimulus(1'b0, 10'h001, 8'h55, 3'd6, 1'b1, 1, 8'h00);
    applyStimulus(1'b0, 10'h002, 8'h66, 3'd3, 1'b1, 1, 8'h00);
    applyResetMidAccess();
    applyStimulus(1'b0, 10'h000, 8'hA5, 3'd3, 1'b0, 1, 8'h00);

    for (int i = 0; i < 200; i++) begin
      ctrl  = 3'($urandom);
      delay = ($urandom_range(0, 7) == 0) ? ACK_TIMEOUT + 1 : int'($urandom_range(1, ACK_TIMEOUT));
      applyStimulus(($urandom_range(0, 7) == 0), 10'($urandom), 8'($urandom), ctrl,
                    1'($urandom_range(0, 1)), delay, 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 15: max cycles oMemReq is held without iMemAck before abort.
REQ-002 SHALL have ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- iValid_EX  in  1  EX presents an instruction this cycle
- oReady_MEM  out  1  stage can accept; instruction transfers when iValid_EX && oReady_MEM
- iBranchTaken_EX  in  1  branch resolved taken by EX ALU
- iBranchDir_EX  in  10  branch target, or store address
- iAluData_EX  in  8  ALU result / store data / constant
- iControlAcum_EX  in  3  000 noLoad, 001 loadConstantA, 010 loadMemoryA, 011 loadConstantB, 100 loadMemoryB
- iMemEnable_EX  in  1  instruction accesses data memory
- oMemReq  out  1  memory request, held until ack
- oMemWrite  out  1  1 = write, 0 = read; valid with oMemReq
- oMemAddr  out  10  memory address
- oMemWrData  out  8  write data
- iMemAck  in  1  memory completes the request this cycle
- iMemRdData  in  8  read data, valid with iMemAck
- oAcumA  out  8  accumulator A
- oAcumB  out  8  accumulator B
- oBranchTaken_MEM  out  1  one-cycle redirect pulse to IF
- oBranchDir_MEM  out  10  redirect target, valid with the pulse
- oRetire  out  1  one-cycle pulse per completed instruction
- oIllegal  out  1  one-cycle pulse on an undefined control code
- oMemErr  out  1  sticky timeout flag

Function
REQ-003 SHALL implement FSM states IDLE and ACCESS; oReady_MEM = 1 only in IDLE.
REQ-004 Accepted op classes:
- iMemEnable_EX=1, iControlAcum_EX=010/100: load
- iMemEnable_EX=1, iControlAcum_EX=000: store
- iMemEnable_EX=0: register op
REQ-005 Register op accepted at edge N: write iAluData_EX to A (001/010) or B (011/100) at edge N; oRetire high cycle N+1; FSM stays IDLE.
REQ-006 Memory op accepted at edge N: latch address/data/dest; enter ACCESS; oMemReq=1 from cycle N+1, oMemAddr=iBranchDir_EX, oMemWrite=1 for store, oMemWrData=iAluData_EX.
REQ-007 In ACCESS, oMemReq/oMemWrite/oMemAddr/oMemWrData SHALL stay constant until the edge sampling iMemAck=1.
- At that edge: load writes iMemRdData to the latched accumulator; oMemReq drops; FSM returns to IDLE; oRetire pulses next cycle.
- Ack in the first ACCESS cycle SHALL be honoured (2-cycle minimum memory op).
REQ-008 Count ACCESS cycles without ack; when the count reaches ACK_TIMEOUT with no ack:
- abort: no accumulator write, oMemErr=1, return to IDLE, oRetire stays 0
- iMemAck=1 in the same cycle as the count is reached SHALL win (normal completion).
REQ-009 Accepted instruction with iBranchTaken_EX=1: oBranchTaken_MEM=1 and oBranchDir_MEM=iBranchDir_EX in cycle N+1 only; oRetire pulses; no accumulator or memory effect.
REQ-010 iMemEnable_EX=1 with code 001/011 SHALL be treated as a register op (memory enable ignored).
REQ-011 iControlAcum_EX in 101..111, or iMemEnable_EX=1 with the invalid combination, SHALL pulse oIllegal in cycle N+1 with no state change and no oRetire.
REQ-012 iValid_EX=0, or any input while oReady_MEM=0, SHALL cause no effect; upstream holds its inputs.
REQ-013 Accumulators SHALL change only as defined in REQ-005/007; oAcumA/oAcumB are registered.
REQ-014 iMemRdData and iMemAck SHALL be ignored in IDLE.

Reset
REQ-015 With reset=1 at a rising edge:
- FSM to IDLE; timeout counter cleared
- oAcumA = oAcumB = 0
- oMemReq, oMemWrite, oBranchTaken_MEM, oRetire, oIllegal, oMemErr = 0
- oMemAddr = 0, oMemWrData = 0, oBranchDir_MEM = 0
REQ-016 Reset during ACCESS SHALL abandon the request (oMemReq=0 next cycle) with no accumulator write; reset SHALL override a simultaneous iMemAck or accept.

Verification
REQ-017 Bench SHALL cover:
- Register op: iValid_EX=1, ctrl=001, data=0x5A, memEn=0 -> oAcumA=0x5A next cycle; oRetire one pulse; oReady_MEM stays 1.
- Load with ack delay 3: ctrl=100, memEn=1, dir=0x123 -> oMemReq=1, oMemWrite=0, addr=0x123 for 3 cycles; iMemRdData=0xC3 with ack -> oAcumB=0xC3; oReady_MEM low throughout.
- Store with immediate ack: ctrl=000, memEn=1, dir=0x3FF, data=0x81 -> one-cycle req with oMemWrite=1, addr=0x3FF, wdata=0x81; accumulators unchanged.
- Timeout: ACK_TIMEOUT=15, load with no ack -> oMemReq drops after 15 cycles; oMemErr=1 sticky; no write; then ack coincident with count 15 on a second load -> completes normally.
- Branch plus illegal: branchTaken=1, dir=0x2A0 -> oBranchTaken_MEM one-cycle pulse with 0x2A0; ctrl=110 -> oIllegal pulse, no oRetire.
- Reset mid-ACCESS, cycle 2: oMemReq=0 next cycle, oAcumA=oAcumB=0, oMemErr=0, FSM IDLE.
